// File: rtl/interrupt_sequencer.sv
// 6502 interrupt entry sequencer: runs the reset, IRQ and NMI flows (stack
// pushes, vector fetch, PC load) and owns the bus while busy is high.
module interrupt_sequencer #(
  parameter logic [15:0] NMI_VECTOR   = 16'hFFFA,
  parameter logic [15:0] RESET_VECTOR = 16'hFFFC,
  parameter logic [15:0] IRQ_VECTOR   = 16'hFFFE,
  parameter logic [7:0]  STACK_PAGE   = 8'h01
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        irq_n,
  input  logic        nmi_n,
  input  logic        i_flag,
  input  logic        instr_boundary,
  input  logic [15:0] pc_in,
  input  logic [7:0]  p_in,
  input  logic [7:0]  sp_in,
  input  logic [7:0]  data_read,
  output logic        busy,
  output logic [15:0] seq_address,
  output logic [7:0]  seq_data_write,
  output logic        seq_read_write,
  output logic        sp_dec,
  output logic        pc_load,
  output logic [15:0] pc_value,
  output logic        i_set
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    PUSH_H = 3'd1,
    PUSH_L = 3'd2,
    PUSH_P = 3'd3,
    VEC_L  = 3'd4,
    VEC_H  = 3'd5,
    LOAD   = 3'd6
  } state_t;

  localparam logic [1:0] KIND_RESET = 2'd0;
  localparam logic [1:0] KIND_IRQ   = 2'd1;
  localparam logic [1:0] KIND_NMI   = 2'd2;

  state_t      state_q, state_d;
  logic [1:0]  kind_q, kind_d;
  logic        nmi_pending_q, nmi_pending_d;
  logic        nmi_prev_q;
  logic [7:0]  vec_lo_q, vec_lo_d;
  logic [7:0]  vec_hi_q, vec_hi_d;
  logic        nmi_set_s;
  logic        nmi_take_s;
  logic        irq_take_s;
  logic [15:0] vec_base_s;

  function automatic logic [15:0] vector_addr(input logic [1:0] kind);
    case (kind)
      KIND_NMI: vector_addr = NMI_VECTOR;
      KIND_IRQ: vector_addr = IRQ_VECTOR;
      default:  vector_addr = RESET_VECTOR;
    endcase
  endfunction

  // Pushed status always carries B=0 and the unused bit 5 set.
  function automatic logic [7:0] pushed_status(input logic [7:0] p);
    pushed_status = (p | 8'b0010_0000) & 8'b1110_1111;
  endfunction

  assign nmi_set_s  = ~nmi_n & nmi_prev_q;
  assign nmi_take_s = (state_q == IDLE) & instr_boundary & nmi_pending_q;
  assign irq_take_s = (state_q == IDLE) & instr_boundary & ~nmi_pending_q
                      & ~irq_n & ~i_flag;
  assign vec_base_s = vector_addr(kind_q);

  // State and capture registers; reset lands directly in the vector fetch.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= VEC_L;
      kind_q        <= KIND_RESET;
      nmi_pending_q <= 1'b0;
      nmi_prev_q    <= 1'b1;
      vec_lo_q      <= 8'h00;
      vec_hi_q      <= 8'h00;
    end else begin
      state_q       <= state_d;
      kind_q        <= kind_d;
      nmi_pending_q <= nmi_pending_d;
      nmi_prev_q    <= nmi_n;
      vec_lo_q      <= vec_lo_d;
      vec_hi_q      <= vec_hi_d;
    end
  end

  // Next-state: arbitration at the boundary, then a fixed walk to LOAD.
  always_comb begin
    state_d       = state_q;
    kind_d        = kind_q;
    vec_lo_d      = vec_lo_q;
    vec_hi_d      = vec_hi_q;
    nmi_pending_d = nmi_set_s | (nmi_pending_q & ~nmi_take_s);
    case (state_q)
      IDLE: begin
        if (nmi_take_s) begin
          state_d = PUSH_H;
          kind_d  = KIND_NMI;
        end else if (irq_take_s) begin
          state_d = PUSH_H;
          kind_d  = KIND_IRQ;
        end else begin
          state_d = IDLE;
        end
      end
      PUSH_H: state_d = PUSH_L;
      PUSH_L: state_d = PUSH_P;
      PUSH_P: state_d = VEC_L;
      VEC_L: begin
        vec_lo_d = data_read;
        state_d  = VEC_H;
      end
      VEC_H: begin
        vec_hi_d = data_read;
        state_d  = LOAD;
      end
      LOAD:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output decode from the current state.
  always_comb begin
    busy           = 1'b1;
    seq_address    = 16'h0000;
    seq_data_write = 8'h00;
    seq_read_write = 1'b1;
    sp_dec         = 1'b0;
    pc_load        = 1'b0;
    i_set          = 1'b0;
    pc_value       = {vec_hi_q, vec_lo_q};
    case (state_q)
      IDLE: begin
        busy = 1'b0;
      end
      PUSH_H: begin
        seq_address    = {STACK_PAGE, sp_in};
        seq_data_write = pc_in[15:8];
        seq_read_write = 1'b0;
        sp_dec         = 1'b1;
      end
      PUSH_L: begin
        seq_address    = {STACK_PAGE, sp_in};
        seq_data_write = pc_in[7:0];
        seq_read_write = 1'b0;
        sp_dec         = 1'b1;
      end
      PUSH_P: begin
        seq_address    = {STACK_PAGE, sp_in};
        seq_data_write = pushed_status(p_in);
        seq_read_write = 1'b0;
        sp_dec         = 1'b1;
      end
      VEC_L: begin
        seq_address = vec_base_s;
      end
      VEC_H: begin
        seq_address = vec_base_s + 16'h0001;
      end
      LOAD: begin
        pc_load = 1'b1;
        i_set   = 1'b1;
      end
      default: begin
        busy = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_interrupt_sequencer.sv
// Scoreboard bench for interrupt_sequencer: stimulus queues the expected bus
// cycle per time stamp, a negedge monitor pops and compares.
module tb_interrupt_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        irq_n;
  logic        nmi_n;
  logic        i_flag;
  logic        instr_boundary;
  logic [15:0] pc_in;
  logic [7:0]  p_in;
  logic [7:0]  sp_in;
  logic [7:0]  data_read;
  logic        busy;
  logic [15:0] seq_address;
  logic [7:0]  seq_data_write;
  logic        seq_read_write;
  logic        sp_dec;
  logic        pc_load;
  logic [15:0] pc_value;
  logic        i_set;

  typedef struct {
    int          cyc;
    logic [15:0] addr;
    logic [7:0]  wdata;
    logic        rw;
    logic [2:0]  strb;
    logic [15:0] pcv;
  } exp_t;

  exp_t exp_q[$];
  exp_t e;
  logic ok;
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_bad = 0;
  logic done = 1'b0;
  logic final_chk = 1'b0;

  interrupt_sequencer dut (
    .clk(clk), .rst(rst), .irq_n(irq_n), .nmi_n(nmi_n), .i_flag(i_flag),
    .instr_boundary(instr_boundary), .pc_in(pc_in), .p_in(p_in),
    .sp_in(sp_in), .data_read(data_read), .busy(busy),
    .seq_address(seq_address), .seq_data_write(seq_data_write),
    .seq_read_write(seq_read_write), .sp_dec(sp_dec), .pc_load(pc_load),
    .pc_value(pc_value), .i_set(i_set)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [7:0] mem_rd(input logic [15:0] a);
    case (a)
      16'hFFFA: mem_rd = 8'hCD;
      16'hFFFB: mem_rd = 8'hAB;
      16'hFFFC: mem_rd = 8'h34;
      16'hFFFD: mem_rd = 8'h12;
      16'hFFFE: mem_rd = 8'h00;
      16'hFFFF: mem_rd = 8'h80;
      default:  mem_rd = 8'hEE;
    endcase
  endfunction

  assign data_read = mem_rd(seq_address);

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_exp(input int c, input logic [15:0] a, input logic [7:0] wd,
                          input logic rw, input logic [2:0] st, input logic [15:0] pv);
    exp_t x;
    x.cyc = c; x.addr = a; x.wdata = wd; x.rw = rw; x.strb = st; x.pcv = pv;
    exp_q.push_back(x);
  endtask

  // Reset flow: released at stamp r, vector read at r, r+1, load at r+2.
  task automatic expect_reset(input int r);
    push_exp(r,     16'hFFFC, 8'h00, 1'b1, 3'b000, 16'h0000);
    push_exp(r + 1, 16'hFFFD, 8'h00, 1'b1, 3'b000, 16'h0000);
    push_exp(r + 2, 16'h0000, 8'h00, 1'b1, 3'b011, 16'h1234);
  endtask

  // Interrupt flow starting from boundary set at stamp n; only steps 1..upto.
  task automatic expect_int(input int n, input logic [7:0] sp, input logic [15:0] pc,
                            input logic [7:0] pstat, input logic [15:0] vec,
                            input logic [15:0] target, input int upto);
    logic [7:0] s1;
    logic [7:0] s2;
    s1 = sp - 8'd1;
    s2 = sp - 8'd2;
    if (upto >= 1) push_exp(n + 1, {8'h01, sp}, pc[15:8], 1'b0, 3'b100, 16'h0000);
    if (upto >= 2) push_exp(n + 2, {8'h01, s1}, pc[7:0],  1'b0, 3'b100, 16'h0000);
    if (upto >= 3) push_exp(n + 3, {8'h01, s2}, pstat,    1'b0, 3'b100, 16'h0000);
    if (upto >= 4) push_exp(n + 4, vec,            8'h00, 1'b1, 3'b000, 16'h0000);
    if (upto >= 5) push_exp(n + 5, vec + 16'h0001, 8'h00, 1'b1, 3'b000, 16'h0000);
    if (upto >= 6) push_exp(n + 6, 16'h0000,       8'h00, 1'b1, 3'b011, target);
  endtask

  task automatic boundary_pulse();
    instr_boundary = 1'b1;
    tick();
    instr_boundary = 1'b0;
  endtask

  // Datapath SP model: one decrement after each of the three push cycles.
  task automatic sp_walk();
    tick(); sp_in = sp_in - 8'd1;
    tick(); sp_in = sp_in - 8'd1;
    tick(); sp_in = sp_in - 8'd1;
  endtask

  task automatic ticks(input int k);
    for (int i = 0; i < k; i++) tick();
  endtask

  // Monitor: reset-state check, scoreboard pop on bus cycles, idle check otherwise.
  always @(negedge clk) begin
    if (done && !final_chk) begin
      final_chk = 1'b1;
      n_cmp = n_cmp + 1;
      if (exp_q.size() != 0) begin
        n_bad = n_bad + 1;
        $display("FAIL leftover_expected: %0d entries never seen, required 0", exp_q.size());
      end
    end
    if (!rst) begin
      n_cmp = n_cmp + 1;
      if (!(busy === 1'b1 && seq_address === 16'hFFFC && seq_read_write === 1'b1 &&
            {sp_dec, pc_load, i_set} === 3'b000)) begin
        n_bad = n_bad + 1;
        $display("FAIL reset_state cyc=%0d: busy=%b addr=%h rw=%b strb=%b, required 1 fffc 1 000",
                 cyc, busy, seq_address, seq_read_write, {sp_dec, pc_load, i_set});
      end
    end else if (busy === 1'b1 || (exp_q.size() != 0 && exp_q[0].cyc == cyc)) begin
      n_cmp = n_cmp + 1;
      if (exp_q.size() == 0) begin
        n_bad = n_bad + 1;
        $display("FAIL unexpected_busy cyc=%0d: addr=%h rw=%b, required idle", cyc,
                 seq_address, seq_read_write);
      end else begin
        e = exp_q.pop_front();
        ok = (busy === 1'b1) && (cyc == e.cyc) && (seq_address === e.addr) &&
             (seq_read_write === e.rw) && ({sp_dec, pc_load, i_set} === e.strb) &&
             (e.rw || seq_data_write === e.wdata) && (!e.strb[1] || pc_value === e.pcv);
        if (!ok) begin
          n_bad = n_bad + 1;
          $display("FAIL bus_cycle cyc=%0d: busy=%b addr=%h wd=%h rw=%b strb=%b pcv=%h, required cyc=%0d busy=1 addr=%h wd=%h rw=%b strb=%b pcv=%h",
                   cyc, busy, seq_address, seq_data_write, seq_read_write,
                   {sp_dec, pc_load, i_set}, pc_value, e.cyc, e.addr, e.wdata, e.rw,
                   e.strb, e.pcv);
        end
      end
    end else begin
      n_cmp = n_cmp + 1;
      if (!(busy === 1'b0 && seq_address === 16'h0000 && seq_data_write === 8'h00 &&
            seq_read_write === 1'b1 && {sp_dec, pc_load, i_set} === 3'b000)) begin
        n_bad = n_bad + 1;
        $display("FAIL idle_outputs cyc=%0d: busy=%b addr=%h wd=%h rw=%b strb=%b, required 0 0000 00 1 000",
                 cyc, busy, seq_address, seq_data_write, seq_read_write,
                 {sp_dec, pc_load, i_set});
      end
    end
  end

  initial begin
    rst = 1'b0; irq_n = 1'b1; nmi_n = 1'b1; i_flag = 1'b0; instr_boundary = 1'b0;
    pc_in = 16'h0000; p_in = 8'h00; sp_in = 8'hFD;

    // Power-on reset and the reset vector flow.
    ticks(3);
    rst = 1'b1;
    expect_reset(cyc);
    ticks(4);

    // IRQ entry; irq_n released mid-sequence must not abort it.
    pc_in = 16'hC012; p_in = 8'hC3; sp_in = 8'hFD; irq_n = 1'b0;
    expect_int(cyc, 8'hFD, 16'hC012, 8'hE3, 16'hFFFE, 16'h8000, 6);
    boundary_pulse();
    irq_n = 1'b1;
    sp_walk();
    ticks(5);

    // Masked IRQ: no sequence at any boundary.
    irq_n = 1'b0; i_flag = 1'b1;
    for (int i = 0; i < 3; i++) begin
      boundary_pulse();
      tick();
    end
    irq_n = 1'b1; i_flag = 1'b0;
    tick();

    // NMI beats a simultaneous IRQ; SP wraps through 00 to FF.
    pc_in = 16'h2000; p_in = 8'h30; sp_in = 8'h01;
    nmi_n = 1'b0; irq_n = 1'b0;
    tick();
    expect_int(cyc, 8'h01, 16'h2000, 8'h20, 16'hFFFA, 16'hABCD, 6);
    boundary_pulse();
    sp_walk();
    ticks(5);
    pc_in = 16'h4321; p_in = 8'hFF; sp_in = 8'hFD;
    expect_int(cyc, 8'hFD, 16'h4321, 8'hEF, 16'hFFFE, 16'h8000, 6);
    boundary_pulse();
    sp_walk();
    ticks(5);
    irq_n = 1'b1; nmi_n = 1'b1;
    tick();

    // NMI edge during the IRQ's PUSH_L is deferred until after IDLE.
    pc_in = 16'h5A5A; p_in = 8'h00; sp_in = 8'hFD; irq_n = 1'b0;
    expect_int(cyc, 8'hFD, 16'h5A5A, 8'h20, 16'hFFFE, 16'h8000, 6);
    boundary_pulse();
    tick(); sp_in = 8'hFC; nmi_n = 1'b0;
    tick(); sp_in = 8'hFB;
    tick(); sp_in = 8'hFA;
    ticks(5);
    irq_n = 1'b1;
    pc_in = 16'h6000;
    expect_int(cyc, 8'hFA, 16'h6000, 8'h20, 16'hFFFA, 16'hABCD, 6);
    boundary_pulse();
    sp_walk();
    ticks(5);
    boundary_pulse();
    ticks(3);
    nmi_n = 1'b1;
    tick();

    // Reset during PUSH_P abandons the push and drops the pending NMI.
    pc_in = 16'h7777; p_in = 8'h00; sp_in = 8'hFD; irq_n = 1'b0;
    expect_int(cyc, 8'hFD, 16'h7777, 8'h20, 16'hFFFE, 16'h8000, 2);
    boundary_pulse();
    tick(); sp_in = 8'hFC; nmi_n = 1'b0;
    tick(); sp_in = 8'hFB; nmi_n = 1'b1; rst = 1'b0;
    ticks(2);
    irq_n = 1'b1;
    rst = 1'b1;
    expect_reset(cyc);
    ticks(4);
    boundary_pulse();
    ticks(3);

    done = 1'b1;
    ticks(2);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
